// File: rtl/toy_bpu_rob_ctrl.sv
// Fetch ROB controller: tags icache requests with ROB entries and retires them
// in order into a single registered decode output stage.
package toy_bpu_rob_ctrl_pkg;
    localparam int unsigned FETCH_DATA_WIDTH = 32;
endpackage

module toy_bpu_rob_ctrl #(
    parameter int unsigned ROB_DEPTH = 8,
    parameter int unsigned W         = toy_bpu_rob_ctrl_pkg::FETCH_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fe_ctrl_flush,
    input  logic                         icache_req_vld,
    output logic                         icache_req_rdy,
    output logic [$clog2(ROB_DEPTH)-1:0] icache_req_rob_id,
    output logic [ROB_DEPTH-1:0]         icache_prealloc,
    input  logic [ROB_DEPTH-1:0]         entry_wait_0,
    input  logic [ROB_DEPTH-1:0]         entry_valid,
    input  logic [ROB_DEPTH-1:0]         entry_invalid,
    input  logic [ROB_DEPTH*W-1:0]       entry_pld,
    output logic [ROB_DEPTH-1:0]         filter_rden,
    output logic [ROB_DEPTH-1:0]         filter_bypass,
    output logic                         dec_vld,
    output logic [W-1:0]                 dec_pld,
    input  logic                         dec_rdy
);

    localparam int unsigned PTR_W = $clog2(ROB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROB_DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             dec_vld_q, dec_vld_d;
    logic [W-1:0]     dec_pld_q, dec_pld_d;

    logic         alloc;
    logic         head_ok;
    logic         out_free;
    logic         do_drop;
    logic         do_read;
    logic         retire;
    logic [W-1:0] head_pld;

    // Head arbitration: a released entry drains without needing the output slot,
    // but only once its icache ack is no longer outstanding.
    always_comb begin
        icache_req_rdy = (count_q != FULL_CNT) && !fe_ctrl_flush;
        alloc          = icache_req_vld && icache_req_rdy;
        head_ok        = (count_q != '0) && !fe_ctrl_flush;
        out_free       = !dec_vld_q || dec_rdy;
        head_pld       = entry_pld[32'(head_q) * W +: W];
        do_drop        = head_ok && entry_invalid[head_q] && !entry_wait_0[head_q];
        do_read        = head_ok && !entry_invalid[head_q] && entry_valid[head_q] && out_free;
        retire         = do_drop || do_read;

        icache_prealloc = alloc   ? (ROB_DEPTH'(1) << tail_q) : '0;
        filter_rden     = do_read ? (ROB_DEPTH'(1) << head_q) : '0;
        filter_bypass   = do_drop ? (ROB_DEPTH'(1) << head_q) : '0;
    end

    // Next-state for pointers, occupancy and the decode output register.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        dec_vld_d = dec_vld_q;
        dec_pld_d = dec_pld_q;

        if (fe_ctrl_flush) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            dec_vld_d = 1'b0;
        end else begin
            if (alloc) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (retire) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({alloc, retire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (do_read) begin
                dec_vld_d = 1'b1;
                dec_pld_d = head_pld;
            end else if (out_free) begin
                dec_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            dec_vld_q <= 1'b0;
            dec_pld_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            dec_vld_q <= dec_vld_d;
            dec_pld_q <= dec_pld_d;
        end
    end

    assign icache_req_rob_id = tail_q;
    assign dec_vld           = dec_vld_q;
    assign dec_pld           = dec_pld_q;

endmodule

// File: tb/tb_toy_bpu_rob_ctrl.sv
// Directed bench for toy_bpu_rob_ctrl: fill, in-order read, drop, backpressure,
// flush and pointer wrap with hand-computed expectations.
module tb_toy_bpu_rob_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PW    = 32;

    logic                   clk;
    logic                   rst_n;
    logic                   fe_ctrl_flush;
    logic                   icache_req_vld;
    logic                   icache_req_rdy;
    logic [2:0]             icache_req_rob_id;
    logic [DEPTH-1:0]       icache_prealloc;
    logic [DEPTH-1:0]       entry_wait_0;
    logic [DEPTH-1:0]       entry_valid;
    logic [DEPTH-1:0]       entry_invalid;
    logic [DEPTH*PW-1:0]    entry_pld;
    logic [DEPTH-1:0]       filter_rden;
    logic [DEPTH-1:0]       filter_bypass;
    logic                   dec_vld;
    logic [PW-1:0]          dec_pld;
    logic                   dec_rdy;

    int checks = 0;
    int errors = 0;

    toy_bpu_rob_ctrl #(.ROB_DEPTH(DEPTH), .W(PW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fe_ctrl_flush     (fe_ctrl_flush),
        .icache_req_vld    (icache_req_vld),
        .icache_req_rdy    (icache_req_rdy),
        .icache_req_rob_id (icache_req_rob_id),
        .icache_prealloc   (icache_prealloc),
        .entry_wait_0      (entry_wait_0),
        .entry_valid       (entry_valid),
        .entry_invalid     (entry_invalid),
        .entry_pld         (entry_pld),
        .filter_rden       (filter_rden),
        .filter_bypass     (filter_bypass),
        .dec_vld           (dec_vld),
        .dec_pld           (dec_pld),
        .dec_rdy           (dec_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and land just after it so registered outputs are stable.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pld(input int idx, input logic [PW-1:0] val);
        entry_pld[idx*PW +: PW] = val;
    endtask

    task automatic flush_once();
        fe_ctrl_flush = 1'b1;
        cyc();
        fe_ctrl_flush = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        fe_ctrl_flush  = 1'b0;
        icache_req_vld = 1'b0;
        entry_wait_0   = '0;
        entry_valid    = '0;
        entry_invalid  = '0;
        entry_pld      = '0;
        dec_rdy        = 1'b0;

        // Reset state
        cyc();
        cyc();
        chk("rst_dec_vld", 64'(dec_vld), 64'd0);
        chk("rst_dec_pld", 64'(dec_pld), 64'd0);
        chk("rst_rob_id", 64'(icache_req_rob_id), 64'd0);
        chk("rst_prealloc", 64'(icache_prealloc), 64'd0);
        chk("rst_rden", 64'(filter_rden), 64'd0);
        chk("rst_bypass", 64'(filter_bypass), 64'd0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", 64'(icache_req_rdy), 64'd1);

        // Fill: 10 requests, the ROB accepts exactly 8
        icache_req_vld = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                chk("fill_prealloc", 64'(icache_prealloc), 64'(1) << i);
                chk("fill_rob_id", 64'(icache_req_rob_id), 64'(i));
                chk("fill_rdy", 64'(icache_req_rdy), 64'd1);
            end else begin
                chk("full_prealloc", 64'(icache_prealloc), 64'd0);
                chk("full_rob_id", 64'(icache_req_rob_id), 64'd0);
                chk("full_rdy", 64'(icache_req_rdy), 64'd0);
            end
            cyc();
            #1;
        end
        icache_req_vld = 1'b0;

        // In-order read of entries 0..3
        entry_valid = 8'h0F;
        for (int i = 0; i < 4; i++) set_pld(i, 32'hA0 + 32'(i));
        dec_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rd_rden", 64'(filter_rden), 64'(1) << k);
            chk("rd_bypass", 64'(filter_bypass), 64'd0);
            cyc();
            chk("rd_dec_vld", 64'(dec_vld), 64'd1);
            chk("rd_dec_pld", 64'(dec_pld), 64'hA0 + 64'(k));
        end

        // One alloc into the freed slot with decode stalled: dec output holds
        dec_rdy        = 1'b0;
        entry_valid    = '0;
        icache_req_vld = 1'b1;
        #1;
        chk("re_alloc_prealloc", 64'(icache_prealloc), 64'h01);
        cyc();
        chk("hold_dec_vld", 64'(dec_vld), 64'd1);
        chk("hold_dec_pld", 64'(dec_pld), 64'hA3);

        // Flush with count=5 and a packet in flight
        fe_ctrl_flush = 1'b1;
        entry_valid   = 8'h10;
        #1;
        chk("flush_rdy", 64'(icache_req_rdy), 64'd0);
        chk("flush_prealloc", 64'(icache_prealloc), 64'd0);
        chk("flush_rden", 64'(filter_rden), 64'd0);
        chk("flush_bypass", 64'(filter_bypass), 64'd0);
        cyc();
        fe_ctrl_flush  = 1'b0;
        icache_req_vld = 1'b0;
        entry_valid    = 8'hFF;
        dec_rdy        = 1'b1;
        #1;
        chk("post_flush_dec_vld", 64'(dec_vld), 64'd0);
        chk("post_flush_rob_id", 64'(icache_req_rob_id), 64'd0);
        chk("post_flush_rdy", 64'(icache_req_rdy), 64'd1);
        chk("empty_no_rden", 64'(filter_rden), 64'd0);
        entry_valid = '0;

        // Drop: entry 1 released, stalled by wait_0 for 3 cycles
        icache_req_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drop_alloc", 64'(icache_prealloc), 64'(1) << i);
            cyc();
        end
        icache_req_vld = 1'b0;
        entry_valid    = 8'h07;
        entry_invalid  = 8'h02;
        entry_wait_0   = 8'h02;
        set_pld(0, 32'hB0);
        set_pld(1, 32'hB1);
        set_pld(2, 32'hB2);
        #1;
        chk("drop_rd0", 64'(filter_rden), 64'h01);
        cyc();
        chk("drop_pld0", 64'(dec_pld), 64'hB0);
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("stall_rden", 64'(filter_rden), 64'd0);
            chk("stall_bypass", 64'(filter_bypass), 64'd0);
            cyc();
            chk("stall_dec_vld", 64'(dec_vld), 64'd0);
        end
        entry_wait_0 = '0;
        #1;
        chk("drop_bypass", 64'(filter_bypass), 64'h02);
        chk("drop_no_rden", 64'(filter_rden), 64'd0);
        cyc();
        chk("drop_dec_vld", 64'(dec_vld), 64'd0);
        #1;
        chk("drop_rd2", 64'(filter_rden), 64'h04);
        cyc();
        chk("drop_dec_vld2", 64'(dec_vld), 64'd1);
        chk("drop_pld2", 64'(dec_pld), 64'hB2);
        entry_valid   = '0;
        entry_invalid = '0;
        cyc();

        // Backpressure: entry 1 waits on dec_rdy
        flush_once();
        icache_req_vld = 1'b1;
        cyc();
        cyc();
        icache_req_vld = 1'b0;
        dec_rdy        = 1'b0;
        entry_valid    = 8'h01;
        set_pld(0, 32'hC0);
        set_pld(1, 32'hC1);
        #1;
        chk("bp_rd0", 64'(filter_rden), 64'h01);
        cyc();
        chk("bp_pld0", 64'(dec_pld), 64'hC0);
        entry_valid = 8'h03;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("bp_no_rden", 64'(filter_rden), 64'd0);
            cyc();
            chk("bp_hold_vld", 64'(dec_vld), 64'd1);
            chk("bp_hold_pld", 64'(dec_pld), 64'hC0);
        end
        dec_rdy = 1'b1;
        #1;
        chk("bp_rd1", 64'(filter_rden), 64'h02);
        cyc();
        chk("bp_pld1", 64'(dec_pld), 64'hC1);
        entry_valid = '0;

        // Wrap: count=8 with head=tail=7, retire and alloc on consecutive cycles
        flush_once();
        icache_req_vld = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        icache_req_vld = 1'b0;
        entry_valid    = 8'h7F;
        for (int i = 0; i < 7; i++) cyc();
        entry_valid    = '0;
        icache_req_vld = 1'b1;
        for (int i = 0; i < 7; i++) cyc();
        chk("wrap_full_rdy", 64'(icache_req_rdy), 64'd0);
        chk("wrap_tail", 64'(icache_req_rob_id), 64'd7);
        entry_valid = 8'h80;
        set_pld(7, 32'hE7);
        #1;
        chk("wrap_no_alloc", 64'(icache_prealloc), 64'd0);
        chk("wrap_rden", 64'(filter_rden), 64'h80);
        cyc();
        chk("wrap_pld", 64'(dec_pld), 64'hE7);
        entry_valid = '0;
        #1;
        chk("wrap_rdy", 64'(icache_req_rdy), 64'd1);
        chk("wrap_prealloc", 64'(icache_prealloc), 64'h80);
        cyc();
        chk("wrap_tail0", 64'(icache_req_rob_id), 64'd0);
        chk("wrap_refull", 64'(icache_req_rdy), 64'd0);
        icache_req_vld = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
